vt_gen: RTL and testbench

VT_GEN -- requirements
Module: vt_gen

---
 rtl/vt_gen.sv | 139 +++++++++++++
 tb/tb_vt_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vt_gen.sv
// Video timing generator: built-in 720p60 / 1080p60 / 480p60 tables plus one
// parameterised custom mode, with registered outputs one cycle behind the counters.
module vt_gen #(
  parameter int   CW         = 12,
  parameter int   C_H_ACTIVE = 1280,
  parameter int   C_H_FRONT  = 110,
  parameter int   C_H_SYNC   = 40,
  parameter int   C_H_BACK   = 220,
  parameter int   C_V_ACTIVE = 720,
  parameter int   C_V_FRONT  = 5,
  parameter int   C_V_SYNC   = 5,
  parameter int   C_V_BACK   = 20,
  parameter logic C_HS_POL   = 1'b0,
  parameter logic C_VS_POL   = 1'b0
) (
  input  logic          pix_clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          line_start,
  output logic [1:0]    mode_active
);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_act, h_fp, h_sw, h_bp;
  logic [CW-1:0] v_act, v_fp, v_sw, v_bp;
  logic [CW-1:0] h_ss, h_se, h_last, v_ss, v_se, v_last;
  logic          h_in, v_in, h_sync_on, v_sync_on, h_wrap, v_wrap;
  logic [1:0]    run_pol, idle_pol;

  // {hsync, vsync} active level for a mode
  function automatic logic [1:0] sync_pol(input logic [1:0] m);
    case (m)
      2'd2:    sync_pol = 2'b00;
      2'd3:    sync_pol = {C_HS_POL, C_VS_POL};
      default: sync_pol = 2'b11;
    endcase
  endfunction

  always_comb begin
    h_act = '0; h_fp = '0; h_sw = '0; h_bp = '0;
    v_act = '0; v_fp = '0; v_sw = '0; v_bp = '0;
    case (mode_active)
      2'd0: begin
        h_act = CW'(1280); h_fp = CW'(110); h_sw = CW'(40); h_bp = CW'(220);
        v_act = CW'(720);  v_fp = CW'(5);   v_sw = CW'(5);  v_bp = CW'(20);
      end
      2'd1: begin
        h_act = CW'(1920); h_fp = CW'(88); h_sw = CW'(44); h_bp = CW'(148);
        v_act = CW'(1080); v_fp = CW'(4);  v_sw = CW'(5);  v_bp = CW'(36);
      end
      2'd2: begin
        h_act = CW'(640); h_fp = CW'(16); h_sw = CW'(96); h_bp = CW'(48);
        v_act = CW'(480); v_fp = CW'(10); v_sw = CW'(2);  v_bp = CW'(33);
      end
      default: begin
        h_act = CW'(C_H_ACTIVE); h_fp = CW'(C_H_FRONT);
        h_sw  = CW'(C_H_SYNC);   h_bp = CW'(C_H_BACK);
        v_act = CW'(C_V_ACTIVE); v_fp = CW'(C_V_FRONT);
        v_sw  = CW'(C_V_SYNC);   v_bp = CW'(C_V_BACK);
      end
    endcase
  end

  assign h_ss   = h_act + h_fp;
  assign h_se   = h_ss + h_sw;
  assign h_last = h_se + h_bp - CW'(1);
  assign v_ss   = v_act + v_fp;
  assign v_se   = v_ss + v_sw;
  assign v_last = v_se + v_bp - CW'(1);

  assign h_in      = h_cnt < h_act;
  assign v_in      = v_cnt < v_act;
  assign h_sync_on = (h_cnt >= h_ss) && (h_cnt < h_se);
  assign v_sync_on = (v_cnt >= v_ss) && (v_cnt < v_se);
  assign h_wrap    = h_cnt == h_last;
  assign v_wrap    = v_cnt == v_last;
  assign run_pol   = sync_pol(mode_active);
  assign idle_pol  = sync_pol(mode);

  // Counters; the mode only switches on the last pixel so a frame never mixes timings
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_active <= 2'd0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_active <= mode;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_wrap) begin
        v_cnt       <= '0;
        mode_active <= mode;
      end else begin
        v_cnt <= v_cnt + CW'(1);
      end
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Output stage; while idle the syncs follow the mode being loaded into mode_active
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!en) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~idle_pol[1];
      vsync       <= ~idle_pol[0];
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      x           <= h_in ? h_cnt : '0;
      y           <= v_in ? v_cnt : '0;
      de          <= h_in && v_in;
      hsync       <= h_sync_on ? run_pol[1] : ~run_pol[1];
      vsync       <= v_sync_on ? run_pol[0] : ~run_pol[0];
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0) && v_in;
    end
  end

endmodule

// File: tb/tb_vt_gen.sv
// Bench for vt_gen built with a tiny 25x12 custom mode; per-cycle expectations and
// hand-derived timing measurements go through queues checked by one monitor.
module tb_vt_gen;
  localparam int CW = 12;

  logic          pix_clk = 1'b0;
  logic          rstn, en;
  logic [1:0]    mode;
  logic [CW-1:0] x, y;
  logic          de, hsync, vsync, frame_start, line_start;
  logic [1:0]    mode_active;

  vt_gen #(
    .CW(CW), .C_H_ACTIVE(16), .C_H_FRONT(2), .C_H_SYNC(3), .C_H_BACK(4),
    .C_V_ACTIVE(8), .C_V_FRONT(1), .C_V_SYNC(1), .C_V_BACK(2),
    .C_HS_POL(1'b0), .C_VS_POL(1'b0)
  ) dut (
    .pix_clk(pix_clk), .rstn(rstn), .en(en), .mode(mode),
    .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .line_start(line_start), .mode_active(mode_active)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de, hs, vs, fs, ls;
    logic [1:0]    ma;
  } out_t;

  // Timing tables: modes 0..2 from the video standards, mode 3 = this bench's custom build
  int HA[4] = '{1280, 1920, 640, 16};
  int HF[4] = '{110, 88, 16, 2};
  int HS[4] = '{40, 44, 96, 3};
  int HB[4] = '{220, 148, 48, 4};
  int VA[4] = '{720, 1080, 480, 8};
  int VF[4] = '{5, 4, 10, 1};
  int VS[4] = '{5, 5, 2, 1};
  int VB[4] = '{20, 36, 33, 2};
  bit HP[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit VP[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  out_t        exp_q[$];
  string       nm_q[$];
  logic [31:0] act_q[$];
  logic [31:0] req_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int   mh, mv;
  logic [1:0] mm;
  out_t s;
  int   cyc, last_fs, last_ls, fs_period, de_acc, de_frame, ls_acc, ls_frame;
  int   line_period, x_max, x_line_max, hs_run, hs_len, hs_off, vs_run, vs_len;
  bit   hs_prev, vs_prev, ls_seen, hs_now, vs_now;
  int   found;

  function automatic out_t dut_out();
    return {x, y, de, hsync, vsync, frame_start, line_start, mode_active};
  endfunction

  function automatic void post(string n, logic [31:0] a, logic [31:0] r);
    nm_q.push_back(n);
    act_q.push_back(a);
    req_q.push_back(r);
  endfunction

  always @(negedge pix_clk) begin
    out_t        a, e;
    string       nm;
    logic [31:0] av, rv;
    a = dut_out();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_out @%0t: actual x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b ma=%0d required x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b ma=%0d",
                 $time, a.x, a.y, a.de, a.hs, a.vs, a.fs, a.ls, a.ma,
                 e.x, e.y, e.de, e.hs, e.vs, e.fs, e.ls, e.ma);
      end
    end
    while (nm_q.size() > 0) begin
      nm = nm_q.pop_front();
      av = act_q.pop_front();
      rv = req_q.pop_front();
      n_cmp++;
      if (av !== rv) begin
        n_bad++;
        $display("FAIL %s: actual %0d required %0d", nm, av, rv);
      end
    end
  end

  task automatic step(input logic e_v, input logic [1:0] m_v);
    out_t ex;
    int   ht, vt;
    en   = e_v;
    mode = m_v;
    @(posedge pix_clk);
    ex = '0;
    if (!rstn) begin
      mh = 0; mv = 0; mm = 2'd0;
    end else if (!e_v) begin
      mh = 0; mv = 0; mm = m_v;
      ex.hs = ~HP[m_v];
      ex.vs = ~VP[m_v];
      ex.ma = m_v;
    end else begin
      ht    = HA[mm] + HF[mm] + HS[mm] + HB[mm];
      vt    = VA[mm] + VF[mm] + VS[mm] + VB[mm];
      ex.de = (mh < HA[mm]) && (mv < VA[mm]);
      ex.x  = (mh < HA[mm]) ? CW'(mh) : '0;
      ex.y  = (mv < VA[mm]) ? CW'(mv) : '0;
      ex.hs = (mh >= HA[mm] + HF[mm] && mh < HA[mm] + HF[mm] + HS[mm]) ? HP[mm] : ~HP[mm];
      ex.vs = (mv >= VA[mm] + VF[mm] && mv < VA[mm] + VF[mm] + VS[mm]) ? VP[mm] : ~VP[mm];
      ex.fs = (mh == 0) && (mv == 0);
      ex.ls = (mh == 0) && (mv < VA[mm]);
      if (mh == ht - 1) begin
        mh = 0;
        if (mv == vt - 1) begin
          mv = 0;
          mm = m_v;
        end else mv++;
      end else mh++;
      ex.ma = mm;
    end
    exp_q.push_back(ex);
    @(negedge pix_clk);
    cyc++;
    s = dut_out();
    if (s.fs) begin
      fs_period = cyc - last_fs; last_fs = cyc;
      de_frame = de_acc; ls_frame = ls_acc; de_acc = 0; ls_acc = 0;
    end
    if (s.de) de_acc++;
    if (s.ls) begin
      line_period = cyc - last_ls; last_ls = cyc; ls_acc++; ls_seen = 1'b1;
      x_line_max = x_max; x_max = 0;
    end
    if (int'(s.x) > x_max) x_max = int'(s.x);
    hs_now = (s.hs == HP[s.ma]);
    if (hs_now && !hs_prev) begin
      hs_run = 1;
      if (ls_seen) begin hs_off = cyc - last_ls; ls_seen = 1'b0; end
    end else if (hs_now) hs_run++;
    else if (hs_prev) hs_len = hs_run;
    hs_prev = hs_now;
    vs_now = (s.vs == VP[s.ma]);
    if (vs_now && !vs_prev) vs_run = 1;
    else if (vs_now) vs_run++;
    else if (vs_prev) vs_len = vs_run;
    vs_prev = vs_now;
  endtask

  initial begin
    rstn = 1'b1; en = 1'b1; mode = 2'd3;
    mh = 0; mv = 0; mm = 2'd0; cyc = 0;
    last_fs = 0; last_ls = 0; fs_period = 0; de_acc = 0; de_frame = 0; ls_acc = 0;
    ls_frame = 0; line_period = 0; x_max = 0; x_line_max = 0; hs_run = 0; hs_len = 0;
    hs_off = 0; vs_run = 0; vs_len = 0; hs_prev = 0; vs_prev = 0; ls_seen = 0; found = 0;
    #1 rstn = 1'b0;
    #2 post("reset_outputs", 32'(dut_out()), 32'd0);
    repeat (3) step(1'b1, 2'd0);

    // Idle in custom mode: syncs parked at the inactive (high) level
    rstn = 1'b1;
    repeat (3) step(1'b0, 2'd3);
    post("idle_hsync", 32'(s.hs), 32'd1);
    post("idle_vsync", 32'(s.vs), 32'd1);
    post("idle_mode_active", 32'(s.ma), 32'd3);

    step(1'b1, 2'd3);
    post("first_frame_start", 32'(s.fs), 32'd1);
    repeat (900) step(1'b1, 2'd3);

    found = 0;
    for (int k = 0; k < 400; k++) begin
      step(1'b1, 2'd3);
      if (s.fs) begin found = 1; break; end
    end
    post("custom_fs_sync", 32'(found), 32'd1);
    repeat (100) step(1'b1, 2'd3);
    post("custom_frame_period", 32'(fs_period), 32'd300);
    post("custom_de_per_frame", 32'(de_frame), 32'd128);
    post("custom_ls_per_frame", 32'(ls_frame), 32'd8);
    post("custom_line_period", 32'(line_period), 32'd25);
    post("custom_hsync_offset", 32'(hs_off), 32'd18);
    post("custom_hsync_len", 32'(hs_len), 32'd3);
    post("custom_vsync_len", 32'(vs_len), 32'd25);
    post("custom_x_max", 32'(x_line_max), 32'd15);

    // Mid-frame mode requests: the value present at the boundary (0) must win
    found = 0;
    for (int k = 0; k < 400; k++) begin
      step(1'b1, 2'd3);
      if (s.fs) begin found = 1; break; end
    end
    post("switch_fs_sync", 32'(found), 32'd1);
    repeat (50) step(1'b1, 2'd0);
    repeat (20) step(1'b1, 2'd2);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      step(1'b1, 2'd0);
      if (s.ma != 2'd3) begin found = 1; break; end
    end
    post("switch_seen", 32'(found), 32'd1);
    post("switch_mode_active", 32'(s.ma), 32'd0);
    post("switch_fs_not_yet", 32'(s.fs), 32'd0);
    step(1'b1, 2'd0);
    post("switch_fs_next", 32'(s.fs), 32'd1);
    post("switch_old_frame_period", 32'(fs_period), 32'd300);
    repeat (3400) step(1'b1, 2'd0);
    post("m0_line_period", 32'(line_period), 32'd1650);
    post("m0_hsync_offset", 32'(hs_off), 32'd1390);
    post("m0_hsync_len", 32'(hs_len), 32'd40);
    post("m0_x_max", 32'(x_line_max), 32'd1279);

    // Abort mid-line, then restart in 640x480
    post("m0_de_before_drop", 32'(s.de), 32'd1);
    step(1'b0, 2'd0);
    post("drop_de", 32'(s.de), 32'd0);
    repeat (10) step(1'b0, 2'd0);
    post("drop_hsync", 32'(s.hs), 32'd0);
    post("drop_vsync", 32'(s.vs), 32'd0);
    repeat (2) step(1'b0, 2'd2);
    post("m2_idle_mode_active", 32'(s.ma), 32'd2);
    post("m2_idle_hsync", 32'(s.hs), 32'd1);
    step(1'b1, 2'd2);
    post("m2_restart_fs", 32'(s.fs), 32'd1);
    repeat (1700) step(1'b1, 2'd2);
    post("m2_line_period", 32'(line_period), 32'd800);
    post("m2_hsync_offset", 32'(hs_off), 32'd656);
    post("m2_hsync_low_len", 32'(hs_len), 32'd96);
    post("m2_x_max", 32'(x_line_max), 32'd639);

    // 1080p mid-line, then asynchronous reset between clock edges
    repeat (2) step(1'b0, 2'd1);
    repeat (1000) step(1'b1, 2'd1);
    post("m1_de_before_rst", 32'(s.de), 32'd1);
    post("m1_mode_active", 32'(s.ma), 32'd1);
    @(posedge pix_clk);
    #2 rstn = 1'b0;
    #1 post("async_reset_outputs", 32'(dut_out()), 32'd0);
    exp_q.delete();
    repeat (2) step(1'b1, 2'd1);
    rstn = 1'b1;
    repeat (2) step(1'b0, 2'd3);
    repeat (320) step(1'b1, 2'd3);
    post("post_reset_frame_period", 32'(fs_period), 32'd300);

    @(negedge pix_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
